tdm_scan_sequencer: RTL and testbench
=====================================

Name: tdm_scan_sequencer

Overview:
- Sequential front-end for the 4:1 multiplexer: drives the mux select lines and samples the mux output.
- Scans the enabled channels in round-robin order. For each channel it holds the select value for a programmable settle time, then captures the mux output bit.
- Completed scans are presented as one N_CH-bit frame on a valid/ready handshake, for a downstream consumer.
- Pairs with the combinational 4:1 mux: sel connects to its select input, mux_y connects to its output.

Parameters:
- N_CH, 4, number of mux channels; must equal 2**SEL_W.
- SEL_W, 2, select width driven to the mux.
- DWELL_W, 4, width of the settle-count input.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one scan; sampled only in IDLE.
- continuous  in  1  sampled with start. 1 = restart a new scan automatically after each frame handshake.
- chan_en  in  N_CH  channel enable mask; latched at start.
- dwell  in  DWELL_W  settle cycles before capture; latched at start.
- mux_y  in  1  mux output being sampled.
- sel  out  SEL_W  mux select.
- busy  out  1  high in any state other than IDLE.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts the frame.
- frame_data  out  N_CH  captured bits; bit i = channel i. Disabled channels read 0.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, busy=0, frame_valid=0, frame_data=0, internal counters and shadow registers = 0.
- State encoding: IDLE, SETTLE, PRESENT.
- IDLE:
  - start=1 and chan_en!=0 → latch chan_en/dwell/continuous into shadow registers; sel = lowest enabled index; cnt = dwell; clear frame register; go to SETTLE.
  - start=1 and chan_en=0 → ignored; remain in IDLE.
- SETTLE:
  - cnt!=0 → cnt decrements; sel held.
  - cnt==0 → at that edge, frame bit [sel] ← mux_y.
    - If a higher enabled channel exists: sel = next enabled index, cnt = dwell_q, stay in SETTLE.
    - Otherwise: go to PRESENT.
  - Each channel occupies exactly dwell_q+1 cycles. dwell=0 captures on the first cycle.
- PRESENT:
  - frame_valid=1; frame_data and sel are stable until handshake.
  - On frame_valid && frame_ready:
    - continuous_q=1 → SETTLE with sel = lowest enabled, cnt = dwell_q, frame register cleared. frame_valid=0 from the next cycle.
    - Otherwise → IDLE.
- Latency: with K enabled channels and dwell D, frame_valid rises K*(D+1) cycles after the edge that samples start.
- start, chan_en and dwell are ignored outside IDLE. Reconfiguration requires a return to IDLE, either by clearing continuous before start or by reset.
- frame_ready is ignored while frame_valid=0. Holding frame_ready high permanently gives back-to-back scans with one PRESENT cycle each.
- In IDLE, sel retains its last value.
- Reset asserted mid-scan discards the partial frame; no frame_valid is produced for it.

Optional Feature:
- Macro: TDM_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SETTLE or PRESENT → next edge goes to IDLE, frame_valid=0, partial frame discarded, sel=0.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE has no effect, and also blocks a simultaneous start.
- Undefined: no abort port; a scan can only be terminated by rst_n.

Test Plan:
- chan_en=4'b1111, dwell=2, continuous=0, mux driven by D=4'b1010 → sel steps 0,1,2,3 with 3 cycles each; frame_valid rises 12 cycles after start; frame_data=4'b1010; returns to IDLE after ready.
- chan_en=4'b0101, dwell=0, D=4'b1111 → sel visits only 0 then 2; frame_valid after 2 cycles; frame_data=4'b0101.
- Backpressure: frame_ready=0 for 5 cycles in PRESENT → frame_valid and frame_data held constant; single handshake on ready; busy drops the next cycle.
- continuous=1, chan_en=4'b0011, dwell=1, frame_ready tied 1 → frames every 5 cycles. Changing chan_en mid-run has no effect.
- start with chan_en=0 → state stays IDLE, busy=0. Also assert rst_n=0 mid-SETTLE → all outputs 0 immediately; no frame emitted.
- With TDM_ABORT_EN: abort during channel 2 of a 4-channel scan → IDLE next cycle, frame_valid never asserts. A new start then completes normally.

Source files
------------

// File: rtl/tdm_scan_sequencer.sv
// tdm_scan_sequencer: sequential front-end for a combinational 4:1 mux.
// Walks the enabled channels in ascending order, holds each select value
// for dwell+1 cycles, captures mux_y on the last cycle, and presents the
// assembled frame on a valid/ready handshake.
// Optional feature: define TDM_ABORT_EN to add an 'abort' input that
// cancels an in-progress scan or pending frame.
module tdm_scan_sequencer #(
    parameter int N_CH    = 4,
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               continuous,
    input  logic [N_CH-1:0]    chan_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_y,
`ifdef TDM_ABORT_EN
    input  logic               abort,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [N_CH-1:0]    frame_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [N_CH-1:0]    en_q, en_d;
    logic               cont_q, cont_d;
    logic [N_CH-1:0]    frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;

    // Enabled channels strictly above the one currently selected.
    logic [N_CH-1:0]    higher_mask;

    // Index of the lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = SEL_W'(i);
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_higher
            assign higher_mask[gi] = en_q[gi] & (sel_q < SEL_W'(gi));
        end
    endgenerate

    // Next-state logic for the scan FSM and its datapath registers.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        en_d          = en_q;
        cont_d        = cont_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;

        case (state_q)
            ST_IDLE: begin
                // An empty mask would never produce a frame, so it is not a scan.
                if (start && (|chan_en)) begin
                    en_d    = chan_en;
                    dwell_d = dwell;
                    cont_d  = continuous;
                    sel_d   = lowest_set(chan_en);
                    cnt_d   = dwell;
                    frame_d = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    frame_d[sel_q] = mux_y;
                    if (|higher_mask) begin
                        sel_d = lowest_set(higher_mask);
                        cnt_d = dwell_q;
                    end else begin
                        state_d       = ST_PRESENT;
                        frame_valid_d = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                if (frame_ready) begin
                    frame_valid_d = 1'b0;
                    if (cont_q) begin
                        state_d = ST_SETTLE;
                        sel_d   = lowest_set(en_q);
                        cnt_d   = dwell_q;
                        frame_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                frame_valid_d = 1'b0;
            end
        endcase

`ifdef TDM_ABORT_EN
        // Abort overrides everything above, including a handshake or a start.
        if (abort) begin
            state_d       = ST_IDLE;
            cnt_d         = cnt_q;
            dwell_d       = dwell_q;
            en_d          = en_q;
            cont_d        = cont_q;
            frame_valid_d = 1'b0;
            if (state_q == ST_IDLE) begin
                sel_d   = sel_q;
                frame_d = frame_q;
            end else begin
                sel_d   = '0;
                frame_d = '0;
            end
        end
`endif
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            dwell_q       <= '0;
            en_q          <= '0;
            cont_q        <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            dwell_q       <= dwell_d;
            en_q          <= en_d;
            cont_q        <= cont_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_q;

endmodule

// File: tb/tb_tdm_scan_sequencer.sv
// Testbench for tdm_scan_sequencer: directed and randomized scans checked
// against a reference built from the scan rules (ascending enabled channels,
// dwell+1 cycles each, frame = mux data masked by the enable set).
module tb_tdm_scan_sequencer;

    localparam int N_CH    = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               continuous;
    logic [N_CH-1:0]    chan_en;
    logic [DWELL_W-1:0] dwell;
    logic               mux_y;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               frame_valid;
    logic               frame_ready;
    logic [N_CH-1:0]    frame_data;
`ifdef TDM_ABORT_EN
    logic               abort;
`endif

    // Data presented at the mux inputs; the mux itself is modelled here.
    logic [N_CH-1:0]    pattern;
    assign mux_y = pattern[sel];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_sel = 0;

    always #5 clk = ~clk;

    tdm_scan_sequencer #(
        .N_CH   (N_CH),
        .SEL_W  (SEL_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .chan_en    (chan_en),
        .dwell      (dwell),
        .mux_y      (mux_y),
`ifdef TDM_ABORT_EN
        .abort      (abort),
`endif
        .sel        (sel),
        .busy       (busy),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One non-continuous scan: start, follow every settle cycle, then hold the
    // frame for ready_delay cycles before accepting it.
    task automatic run_scan(input logic [N_CH-1:0] en, input int d,
                            input logic [N_CH-1:0] pat, input int ready_delay);
        int               exp_sel[$];
        logic [N_CH-1:0]  exp_frame;
        exp_sel = {};
        for (int ch = 0; ch < N_CH; ch++)
            if (en[ch])
                for (int k = 0; k <= d; k++) exp_sel.push_back(ch);
        exp_frame = pat & en;

        pattern    = pat;
        chan_en    = en;
        dwell      = DWELL_W'(d);
        continuous = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;

        for (int c = 0; c < exp_sel.size(); c++) begin
            check("scan_sel", 32'(sel), 32'(exp_sel[c]));
            check("scan_busy", 32'(busy), 32'd1);
            check("scan_valid_low", 32'(frame_valid), 32'd0);
            // These must all be ignored while a scan is running.
            chan_en     = N_CH'($urandom);
            dwell       = DWELL_W'($urandom);
            frame_ready = 1'($urandom);
            tick();
        end

        frame_ready = 1'b0;
        check("frame_valid", 32'(frame_valid), 32'd1);
        check("frame_data", 32'(frame_data), 32'(exp_frame));
        check("present_sel", 32'(sel), 32'(exp_sel[exp_sel.size()-1]));
        for (int w = 0; w < ready_delay; w++) begin
            pattern = N_CH'($urandom);
            tick();
            check("hold_valid", 32'(frame_valid), 32'd1);
            check("hold_data", 32'(frame_data), 32'(exp_frame));
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(frame_valid), 32'd0);
        check("idle_sel_kept", 32'(sel), 32'(exp_sel[exp_sel.size()-1]));
        last_sel = exp_sel[exp_sel.size()-1];
        $display("scan en=%b dwell=%0d pat=%b delay=%0d -> frame %b", en, d, pat,
                 ready_delay, exp_frame);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        chan_en     = '0;
        dwell       = '0;
        frame_ready = 1'b0;
        pattern     = '0;
`ifdef TDM_ABORT_EN
        abort       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Directed scans.
        run_scan(4'b1111, 2, 4'b1010, 0);
        run_scan(4'b0101, 0, 4'b1111, 0);
        run_scan(4'b1111, 1, 4'b0110, 5);
        run_scan(4'b1100, 0, 4'b0100, 1);

        // Start with an empty mask is ignored; sel keeps its last value.
        chan_en = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_sel", 32'(sel), 32'(last_sel));
        tick();
        check("empty_busy2", 32'(busy), 32'd0);
        check("empty_valid", 32'(frame_valid), 32'd0);
        $display("empty-mask start ignored");

        // Continuous mode, ready tied high: one frame every K*(D+1)+1 cycles.
        pattern     = 4'b1101;
        chan_en     = 4'b0011;
        dwell       = 4'd1;
        continuous  = 1'b1;
        frame_ready = 1'b1;
        start       = 1'b1;
        tick();
        start      = 1'b0;
        continuous = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chan_en = 4'b1111;
            tick();
            check("cont_valid", 32'(frame_valid), 32'((c % 5) == 4));
            check("cont_sel", 32'(sel), 32'((c % 5) >= 2));
            check("cont_busy", 32'(busy), 32'd1);
            if ((c % 5) == 4) begin
                check("cont_data", 32'(frame_data), 32'(4'b1101 & 4'b0011));
                $display("continuous frame at cycle %0d", c);
            end
        end
        tick();
        // Asynchronous reset mid-settle clears everything at once.
        rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        check("midrst_data", 32'(frame_data), 32'd0);
        tick();
        rst_n       = 1'b1;
        frame_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("postrst_valid", 32'(frame_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
        end
        $display("mid-scan reset discarded frame");

`ifdef TDM_ABORT_EN
        // Abort while channel 2 is being settled.
        pattern = 4'b1111;
        chan_en = 4'b1111;
        dwell   = 4'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("abort_pre_sel", 32'(sel), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(sel), 32'd0);
        check("abort_valid", 32'(frame_valid), 32'd0);
        check("abort_data", 32'(frame_data), 32'd0);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("abort_no_valid", 32'(frame_valid), 32'd0);
        end
        // Abort in IDLE blocks a simultaneous start.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_blocks_start", 32'(busy), 32'd0);
        $display("abort handled");
        run_scan(4'b1111, 1, 4'b1001, 0);
`endif

        // Randomized scans.
        for (int it = 0; it < 20; it++) begin
            logic [N_CH-1:0] en;
            en = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            run_scan(en, int'($urandom_range(0, 4)), N_CH'($urandom),
                     int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
